// File: rtl/spi_adc128s_slave.sv
// SPI mode-3 slave front end for the ADC128S behavioural model: shifts a 16-bit
// command in on MOSI while shifting A2D_data out on MISO, then flags rdy.
module spi_adc128s_slave (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [15:0] A2D_data,
  output logic [15:0] cmd,
  output logic        rdy
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  logic       ss_n_ff1_q, ss_n_ff2_q, ss_n_ff3_q;
  logic       sclk_ff1_q, sclk_ff2_q, sclk_ff3_q;
  logic       mosi_ff1_q, mosi_ff2_q;

  state_t      state_q;
  logic [15:0] shft_q;
  logic [4:0]  bit_cnt_q;
  logic [4:0]  bit_cnt_d;
  logic [15:0] cmd_q;
  logic        rdy_q;

  logic ss_fall_s, ss_rise_s, sclk_rise_s;

  // Pin synchronizers; SS_n and SCLK idle high so they reset to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_n_ff1_q <= 1'b1;
      ss_n_ff2_q <= 1'b1;
      ss_n_ff3_q <= 1'b1;
      sclk_ff1_q <= 1'b1;
      sclk_ff2_q <= 1'b1;
      sclk_ff3_q <= 1'b1;
      mosi_ff1_q <= 1'b0;
      mosi_ff2_q <= 1'b0;
    end else begin
      ss_n_ff1_q <= SS_n;
      ss_n_ff2_q <= ss_n_ff1_q;
      ss_n_ff3_q <= ss_n_ff2_q;
      sclk_ff1_q <= SCLK;
      sclk_ff2_q <= sclk_ff1_q;
      sclk_ff3_q <= sclk_ff2_q;
      mosi_ff1_q <= MOSI;
      mosi_ff2_q <= mosi_ff1_q;
    end
  end

  assign ss_fall_s   = ss_n_ff3_q & ~ss_n_ff2_q;
  assign ss_rise_s   = ~ss_n_ff3_q & ss_n_ff2_q;
  assign sclk_rise_s = ~sclk_ff3_q & sclk_ff2_q;

  // Bit counter saturates at 16 so over-long frames still complete
  always_comb begin
    if (bit_cnt_q == 5'd16) begin
      bit_cnt_d = bit_cnt_q;
    end else begin
      bit_cnt_d = bit_cnt_q + 5'd1;
    end
  end

  // Frame FSM and datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shft_q    <= 16'h0000;
      bit_cnt_q <= 5'd0;
      cmd_q     <= 16'h0000;
      rdy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_fall_s) begin
            shft_q    <= A2D_data;
            bit_cnt_q <= 5'd0;
            rdy_q     <= 1'b0;
            state_q   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (ss_rise_s) begin
            if (bit_cnt_q == 5'd16) begin
              cmd_q <= shft_q;
              rdy_q <= 1'b1;
            end
            state_q <= IDLE;
          end else if (sclk_rise_s) begin
            shft_q    <= {shft_q[14:0], mosi_ff2_q};
            bit_cnt_q <= bit_cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Drive the bus only while the synchronized select is asserted
  assign MISO = ss_n_ff2_q ? 1'bz : shft_q[15];
  assign cmd  = cmd_q;
  assign rdy  = rdy_q;

endmodule

// File: tb/tb_spi_adc128s_slave.sv
// Directed bench for spi_adc128s_slave: a bit-banged mode-3 master with
// hand-computed expected command/response words.
module tb_spi_adc128s_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [15:0] A2D_data = 16'h0000;
  logic [15:0] cmd;
  logic        rdy;

  int err_cnt = 0;
  int chk_cnt = 0;
  int rdy_rises = 0;
  logic rdy_prev = 1'b0;

  spi_adc128s_slave dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .A2D_data(A2D_data), .cmd(cmd), .rdy(rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdy_prev <= rdy;
    if (rdy && !rdy_prev) rdy_rises <= rdy_rises + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master: MOSI changes on SCLK fall, MISO sampled on SCLK rise
  task automatic spi_frame(input logic [31:0] tx, input int nbits, input logic [15:0] a2d,
                           input int chg_at, output logic [31:0] rx);
    A2D_data = a2d;
    rx = 32'h0;
    SS_n = 1'b0;
    wait_clk(6);
    for (int i = nbits - 1; i >= 0; i--) begin
      SCLK = 1'b0;
      MOSI = tx[i];
      if ((nbits - 1 - i) == chg_at) A2D_data = 16'hFFFF;
      wait_clk(5);
      SCLK = 1'b1;
      rx = {rx[30:0], MISO};
      wait_clk(5);
    end
    wait_clk(1);
    SS_n = 1'b1;
  endtask

  task automatic wait_rdy(input logic level, output int n);
    n = 0;
    while ((rdy !== level) && (n < 10)) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    logic [31:0] rx;
    int n;
    int rises0;

    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    check("reset_cmd", {16'h0, cmd}, 32'h0);
    check("reset_rdy", {31'h0, rdy}, 32'h0);
    check("reset_miso_z", {31'h0, (MISO === 1'bz)}, 32'h1);

    // Basic frame: channel 4
    spi_frame(32'h2000, 16, 16'h0C00, -1, rx);
    wait_rdy(1'b1, n);
    check("basic_rdy_lat", {31'h0, (n >= 3 && n <= 4)}, 32'h1);
    check("basic_rx", rx, 32'h0C00);
    check("basic_cmd", {16'h0, cmd}, 32'h2000);
    check("idle_miso_z", {31'h0, (MISO === 1'bz)}, 32'h1);

    // rdy clears after the next SS_n fall
    wait_clk(3);
    A2D_data = 16'h0BF0;
    SS_n = 1'b0;
    wait_rdy(1'b0, n);
    check("rdy_clear_lat", {31'h0, (n <= 4 && rdy === 1'b0)}, 32'h1);
    spi_frame(32'h2800, 16, 16'h0BF0, -1, rx);
    wait_rdy(1'b1, n);
    check("second_rdy", {31'h0, rdy}, 32'h1);
    check("second_rx", rx, 32'h0BF0);
    check("second_cmd", {16'h0, cmd}, 32'h2800);

    // Aborted frame of 8 bits
    wait_clk(4);
    spi_frame(32'h00AA, 8, 16'h1111, -1, rx);
    wait_clk(8);
    check("abort_cmd", {16'h0, cmd}, 32'h2800);
    check("abort_rdy", {31'h0, rdy}, 32'h0);

    // A2D_data change mid-frame must not disturb the frame
    spi_frame(32'h3000, 16, 16'h0A5A, 7, rx);
    wait_rdy(1'b1, n);
    check("stable_rx", rx, 32'h0A5A);
    check("stable_cmd", {16'h0, cmd}, 32'h3000);

    // Reset in the middle of a frame
    wait_clk(4);
    A2D_data = 16'h5555;
    SS_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 5; i++) begin
      SCLK = 1'b0; MOSI = 1'b1; wait_clk(5);
      SCLK = 1'b1; wait_clk(5);
    end
    rst = 1'b1;
    wait_clk(2);
    check("midrst_cmd", {16'h0, cmd}, 32'h0);
    check("midrst_miso_z", {31'h0, (MISO === 1'bz)}, 32'h1);
    SS_n = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(10);
    check("midrst_rdy", {31'h0, rdy}, 32'h0);
    check("midrst_cmd_after", {16'h0, cmd}, 32'h0);

    // Over-long frame: last 16 bits win, MISO returns shifted-in data
    spi_frame(32'hABCDE, 20, 16'h1234, -1, rx);
    wait_rdy(1'b1, n);
    check("long_rdy", {31'h0, rdy}, 32'h1);
    check("long_cmd", {16'h0, cmd}, 32'hBCDE);
    check("long_rx", rx, 32'h1234A);

    // SCLK activity while deselected is ignored
    for (int i = 0; i < 6; i++) begin
      SCLK = 1'b0; MOSI = 1'b0; wait_clk(5);
      SCLK = 1'b1; wait_clk(5);
    end
    check("desel_cmd", {16'h0, cmd}, 32'hBCDE);
    check("desel_rdy", {31'h0, rdy}, 32'h1);
    check("desel_miso_z", {31'h0, (MISO === 1'bz)}, 32'h1);

    // Back-to-back frames with 4-clk gaps
    rises0 = rdy_rises;
    begin
      logic [15:0] b2b [4];
      b2b[0] = 16'h0000; b2b[1] = 16'h2000; b2b[2] = 16'h2800; b2b[3] = 16'hFFFF;
      for (int f = 0; f < 4; f++) begin
        spi_frame({16'h0, b2b[f]}, 16, 16'h0C00 + 16'(f), -1, rx);
        wait_clk(4);
        check("b2b_rdy", {31'h0, rdy}, 32'h1);
        check("b2b_cmd", {16'h0, cmd}, {16'h0, b2b[f]});
        check("b2b_rx", rx, {16'h0, 16'h0C00 + 16'(f)});
      end
    end
    wait_clk(4);
    check("b2b_rdy_pulses", rdy_rises - rises0, 32'd4);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/spi_adc128s_slave.md
# spi_adc128s_slave

SPI slave front end for the behavioural ADC128S A2D model. It shifts a 16-bit command in from the SPI master on MOSI while shifting 16-bit conversion data out on MISO. After each complete frame it presents the received command word with a `rdy` flag. The wrapping ADC model uses that flag to update its channel pointer and to supply the next `A2D_data`.

## Interface
Clock and reset: one clock; reset is asynchronous and active-high.

No parameters. Frame length is fixed at 16 bits.

Ports:
- `clk` input 1: system clock, much faster than SCLK.
- `rst` input 1: asynchronous, active-high reset.
- `SS_n` input 1: active-low slave select from the master.
- `SCLK` input 1: serial clock from the master, idles high.
- `MOSI` input 1: serial data from the master, MSB first.
- `MISO` output 1: serial data to the master, MSB first. High-Z while `SS_n` is high.
- `A2D_data` input 16: word to transmit, sampled at frame start.
- `cmd` output 16: last complete received word.
- `rdy` output 1: high once a complete frame has been received.

## Operation
- `SS_n`, `SCLK` and `MOSI` each pass through a 2-flop synchronizer into the `clk` domain.
- A third flop on `SS_n` and on `SCLK` provides edge detection.
- Synchronizer flops reset to 1 for `SS_n` and `SCLK`, and to 0 for `MOSI`.
- The datapath is a 16-bit shift register `shft` plus a 5-bit bit counter `bit_cnt`.
- SPI mode 3: the master changes MOSI on SCLK fall and samples MISO on SCLK rise. The slave samples MOSI on SCLK rise.

States:
- IDLE:
  - On a detected SS_n fall: `shft <= A2D_data`, `bit_cnt <= 0`, `rdy <= 0`, go to ACTIVE.
- ACTIVE:
  - On each detected SCLK rise: `shft <= {shft[14:0], MOSI_sync}`. `bit_cnt` increments and saturates at 16.
  - On a detected SS_n rise with `bit_cnt == 16`: `cmd <= shft`, `rdy <= 1`, go to IDLE.
  - On a detected SS_n rise with `bit_cnt != 16` (aborted frame): `cmd` and `rdy` stay unchanged, go to IDLE.

Output rules:
- `MISO = shft[15]` whenever synchronized `SS_n` is low; high-Z otherwise.
- More than 16 SCLK rises in a frame: shifting continues, and `cmd` takes the last 16 bits received.
- SCLK edges while `SS_n` is high are ignored.
- `rdy` stays high until the next SS_n fall is detected. A new completed frame overwrites `cmd`.
- `A2D_data` changes during a frame do not affect the frame in progress.

Reset values: `cmd = 16'h0000`, `rdy = 0`, `shft = 0`, `bit_cnt = 0`, state IDLE, so `MISO` is high-Z. Reset mid-frame aborts the frame immediately.

## Timing
- Edge detection latency is 3 `clk` from a pin edge to the corresponding action.
- From SS_n fall to `MISO` = `A2D_data[15]` is at most 4 `clk`.
- After each SCLK rise, `MISO` advances to the next bit within 4 `clk`. This is legal because the master already sampled the previous bit at that edge.
- Requirements on the master's timing:
  - SCLK high and low phases each last at least 4 `clk`.
  - SS_n-fall to first SCLK fall lasts at least 4 `clk`.
  - Last SCLK rise to SS_n rise lasts at least 4 `clk`.
- `rdy` rises 3–4 `clk` after SS_n rises, with `cmd` valid on the same cycle.

## Test plan
- **Reset:** assert `rst` mid-frame, then release → `cmd = 0`, `rdy = 0`, `MISO` = Z, no spurious `rdy`.
- **Basic frame:** `A2D_data = 16'h0C00`; master sends `16'h2000` (channel 4) → master receives `0x0C00`, `cmd = 16'h2000`, `rdy` rises about 3 `clk` after SS_n rises.
- **rdy clear:** start a second frame → `rdy` drops within 4 `clk` of SS_n falling. Send `16'h2800` with `A2D_data = 16'h0BF0` → master receives `0x0BF0`, `cmd = 16'h2800`.
- **Abort:** lower SS_n, give 8 SCLK pulses, raise SS_n → `cmd` keeps its previous value and `rdy` stays 0.
- **Data stability:** change `A2D_data` to `16'hFFFF` mid-frame while the original is `16'h0A5A` → master still receives `0x0A5A`.
- **Back-to-back:** 4 frames with cmd `0x0000`, `0x2000`, `0x2800`, `0xFFFF` and gaps of 4 `clk` → every `cmd` is correct and `rdy` pulses once per frame.
